// File: rtl/pipe_skid_reg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_reg_pkg : F->D payload layout, nop payload, skid stage state enum
// Revision: 1.0
// ---------------------------------------------------------------------------
package pipe_skid_reg_pkg;

  localparam int FD_INSTR_W    = 32;
  localparam int FD_PC_W       = 64;
  localparam int FD_PAYLOAD_W  = 161;
  localparam int FD_INSTR_LSB  = 0;
  localparam int FD_PC_LSB     = 32;
  localparam int FD_PRE_PC_LSB = 96;
  localparam int FD_COMMIT_LSB = 160;

  // Canonical bubble: addi x0,x0,0 at pc 0, never committed
  localparam logic [FD_INSTR_W-1:0] nop_instr  = 32'h0000_0013;
  localparam logic [FD_PC_W-1:0]    nop_pc     = 64'h0;
  localparam logic [FD_PC_W-1:0]    nop_pre_pc = 64'h0;
  localparam logic                  nop_commit = 1'b0;

  function automatic logic [FD_PAYLOAD_W-1:0] fd_pack(
    input logic [FD_INSTR_W-1:0] instr,
    input logic [FD_PC_W-1:0]    pc,
    input logic [FD_PC_W-1:0]    pre_pc,
    input logic                  commit
  );
    logic [FD_PAYLOAD_W-1:0] p;
    p = '0;
    p[FD_INSTR_LSB  +: FD_INSTR_W] = instr;
    p[FD_PC_LSB     +: FD_PC_W]    = pc;
    p[FD_PRE_PC_LSB +: FD_PC_W]    = pre_pc;
    p[FD_COMMIT_LSB]               = commit;
    return p;
  endfunction

  localparam logic [FD_PAYLOAD_W-1:0] nop = fd_pack(nop_instr, nop_pc, nop_pre_pc, nop_commit);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg_sat_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_sat_cnt : accumulator of 0..3 per cycle that saturates at all-ones
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   add,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (W+1)'(add);
    cnt_d = cnt_q;
    if (sum > {1'b0, {W{1'b1}}}) cnt_d = {W{1'b1}};
    else                         cnt_d = sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_reg : two-entry skid buffer with registered ready and flush drop count
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = 161,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(nop),
  parameter int               DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_data_o,
  output logic [1:0]        count_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_valid, skid_valid;
  logic             in_fire, out_fire;
  logic [1:0]       drop_add;

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);

  // Ready comes straight from state so out_ready_i never reaches upstream
  assign in_ready_o  = ~skid_valid;
  assign out_valid_o = main_valid;
  assign out_data_o  = main_q;
  assign count_o     = {1'b0, main_valid} + {1'b0, skid_valid};

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = ST_FULL;
          end else if (out_fire) begin
            main_d  = NOP_VALUE;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Everything held at flush counts as dropped, even an entry leaving that cycle
  assign drop_add = flush_i ? count_o : 2'd0;

  pipe_sat_cnt #(
    .W (DROP_W)
  ) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .add (drop_add),
    .cnt (drop_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg : directed and scoreboarded checks of pipe_skid_reg
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int W = 161;
  localparam logic [W-1:0]   EXP_NOP = {1'b0, 64'h0, 64'h0, 32'h0000_0013};
  localparam logic [152:0]   HI      = 153'h1_0123456789ABCDEF_0123456789ABCDEF_012345;

  logic         clk = 1'b0;
  logic         rst, flush_i, in_valid_i, out_ready_i;
  logic [W-1:0] in_data_i;
  logic         in_ready_o, out_valid_o;
  logic [W-1:0] out_data_o;
  logic [1:0]   count_o;
  logic [7:0]   drop_cnt_o;
  logic         in_ready2, out_valid2;
  logic [W-1:0] out_data2;
  logic [1:0]   count2;
  logic [1:0]   drop_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .count_o(count_o), .drop_cnt_o(drop_cnt_o)
  );

  pipe_skid_reg #(.DROP_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready2), .in_data_i(in_data_i),
    .out_valid_o(out_valid2), .out_ready_i(out_ready_i), .out_data_o(out_data2),
    .count_o(count2), .drop_cnt_o(drop_cnt2)
  );

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] b);
    return {HI, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_out_valid"}, W'(out_valid_o), W'(0));
    check_val({tag, "_in_ready"},  W'(in_ready_o),  W'(1));
    check_val({tag, "_count"},     W'(count_o),     W'(0));
    check_val({tag, "_out_data"},  out_data_o,      EXP_NOP);
    check_val({tag, "_drop"},      W'(drop_cnt_o),  W'(0));
    check_val({tag, "_drop2"},     W'(drop_cnt2),   W'(0));
  endtask

  task automatic push_two();
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    in_data_i = mk(8'hA1); step();
    in_data_i = mk(8'hA2); step();
    in_valid_i = 1'b0;
  endtask

  logic [W-1:0] sb[$];
  logic [W-1:0] exp_front;
  logic [191:0] rnd;
  logic         rdy_before;
  int           sent, recv, cyc;

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
    step(); step();
    check_reset_vals("reset");

    // Single transfer: one-cycle latency, then drain
    rst = 1'b0; in_valid_i = 1'b1; in_data_i = mk(8'hA1); out_ready_i = 1'b1;
    step();
    check_val("lat_valid", W'(out_valid_o), W'(1));
    check_val("lat_data",  out_data_o,      mk(8'hA1));
    check_val("lat_count", W'(count_o),     W'(1));
    in_valid_i = 1'b0;
    step();
    check_val("drain_count", W'(count_o), W'(0));
    check_val("drain_data",  out_data_o,  EXP_NOP);

    // Fill, hold off A3, then release in order
    push_two();
    check_val("full_count", W'(count_o),    W'(2));
    check_val("full_ready", W'(in_ready_o), W'(0));
    check_val("full_data",  out_data_o,     mk(8'hA1));
    in_valid_i = 1'b1; in_data_i = mk(8'hA3);
    step();
    check_val("hold_count", W'(count_o), W'(2));
    check_val("hold_data",  out_data_o,  mk(8'hA1));
    out_ready_i = 1'b1;
    step();
    check_val("ord_a2", out_data_o, mk(8'hA2));
    check_val("ord_a2_count", W'(count_o), W'(1));
    step();
    check_val("ord_a3", out_data_o, mk(8'hA3));
    in_valid_i = 1'b0;
    step();
    check_val("ord_empty", W'(out_valid_o), W'(0));

    // Flush from FULL with a concurrent input
    push_two();
    flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = mk(8'hA3);
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check_val("flush_count", W'(count_o),    W'(0));
    check_val("flush_data",  out_data_o,     EXP_NOP);
    check_val("flush_drop",  W'(drop_cnt_o), W'(2));
    check_val("flush_valid", W'(out_valid_o), W'(0));
    step();
    check_val("flush_no_a3", W'(out_valid_o), W'(0));

    // Flush with an entry leaving in the same cycle still counts it
    in_valid_i = 1'b1; in_data_i = mk(8'hB1); out_ready_i = 1'b0;
    step();
    in_valid_i = 1'b0; out_ready_i = 1'b1; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check_val("flush_out_drop", W'(drop_cnt_o), W'(3));

    // Saturation on the narrow counter
    rst = 1'b1; step(); rst = 1'b0;
    push_two(); flush_i = 1'b1; step(); flush_i = 1'b0;
    check_val("sat_1", W'(drop_cnt2), W'(2));
    push_two(); flush_i = 1'b1; step(); flush_i = 1'b0;
    check_val("sat_2", W'(drop_cnt2), W'(3));
    push_two(); flush_i = 1'b1; step(); flush_i = 1'b0;
    check_val("sat_3", W'(drop_cnt2), W'(3));
    check_val("wide_6", W'(drop_cnt_o), W'(6));

    // Reset wins over flush while FULL
    push_two();
    rst = 1'b1; flush_i = 1'b1;
    step();
    rst = 1'b0; flush_i = 1'b0;
    check_reset_vals("rst_flush");

    // Random stream with scoreboard
    sent = 0; recv = 0; cyc = 0;
    while ((recv < 100) && (cyc < 2000)) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_valid_i = (sent < 100);
      in_data_i  = rnd[W-1:0];
      rdy_before = in_ready_o;
      out_ready_i = 1'($urandom_range(0, 1));
      #1;
      check_val("ready_indep", W'(in_ready_o), W'(rdy_before));
      check_val("rand_count", W'(count_o), W'(sb.size()));
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check_val("rand_spurious", W'(out_valid_o), W'(0));
        end else begin
          exp_front = sb.pop_front();
          check_val("rand_data", out_data_o, exp_front);
          recv++;
        end
      end
      if (in_valid_i && in_ready_o) begin
        sb.push_back(in_data_i);
        sent++;
      end
      step();
      cyc++;
    end
    in_valid_i = 1'b0;
    check_val("rand_recv", W'(recv), W'(100));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
